mips_alu_ctrl: RTL and testbench
================================

# mips_alu_ctrl

Execute-stage decode and arithmetic unit of the five-stage MIPS pipeline. It decodes the instruction opcode into main control signals and derives the 4-bit ALU operation from aluop and funct. It selects ALU operand B and computes the result and zero flag. All outputs are registered once, forming the EX boundary register consumed by the MEM stage.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction bits [31:26].
- funct  in  6  instruction bits [5:0].
- rs_data  in  32  ALU operand A (already forwarded).
- rt_data  in  32  register operand for B (already forwarded).
- seimm  in  32  sign-extended immediate.
- bubble  in  1  insert NOP: clear all registered outputs.
- hold  in  1  freeze all registered outputs.
- regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump  out  1 each  registered main-control flags.
- aluop  out  2  registered ALU op class.
- aluctl  out  4  registered ALU operation code.
- alurslt  out  32  registered ALU result.
- zero  out  1  registered, set when the ALU result is 0.

## Operation
- Main decode by opcode; any flag not listed is 0:
  - 0x00 R-type: regdst, regwrite, aluop=10.
  - 0x23 lw: memread, memtoreg, alusrc, regwrite, aluop=00.
  - 0x2B sw: memwrite, alusrc, aluop=00.
  - 0x04 beq: branch_eq, aluop=01.
  - 0x05 bne: branch_ne, aluop=01.
  - 0x08 addi: alusrc, regwrite, aluop=00.
  - 0x02 j: jump.
  - Any other opcode: all flags 0, aluop=00.
- ALU control:
  - aluop=00 gives add (0010).
  - aluop=01 gives sub (0110).
  - aluop=11 gives add (0010).
  - aluop=10 decodes funct: 0x20 add 0010, 0x22 sub 0110, 0x24 and 0000, 0x25 or 0001, 0x2A slt 0111, 0x27 nor 1100. Any other funct gives 0010.
- Operand B = alusrc ? seimm : rt_data.
- ALU operations:
  - 0000 AND; 0001 OR.
  - 0010 add, modulo 2^32, no overflow trap.
  - 0110 subtract, modulo 2^32.
  - 0111 signed set-less-than: result 1 or 0.
  - 1100 NOR.
  - 1101 XOR, only with the Configuration macro defined.
  - Any other code gives 0.
- zero = (result == 0), computed on the final result.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Register update priority per edge: rst, then bubble, then hold, then normal load.
- rst: every output is 0, including zero, aluop and aluctl.
- bubble: identical to reset values (NOP). It overrides hold when both are asserted.
- hold: all outputs keep their previous values.
- Reset mid-stream discards the in-flight instruction; the next edge without rst loads normally.
- Decode and ALU paths are purely combinational ahead of the register; no other state exists.

## Configuration
- MIPS_ALU_XOR_EN defined:
  - funct 0x26 with aluop=10 maps to aluctl 1101.
  - The ALU computes A XOR B for 1101.
- MIPS_ALU_XOR_EN undefined:
  - funct 0x26 maps to 0010 (add).
  - aluctl 1101 yields result 0.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - funct constants;
  - aluop encodings;
  - aluctl encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_XOR).
- One natural sub-module, `mips_alu_core`: combinational 32-bit ALU with inputs ctl, a, b and outputs out, zero.
- Main decode, ALU-control decode and the output register stay in the top module.

## Test plan
- R-type add: opcode 0x00, funct 0x20, rs_data 5, rt_data 3 -> next cycle alurslt 8, zero 0, regdst 1, regwrite 1, aluctl 0010.
- beq taken: opcode 0x04, rs_data 0x1234, rt_data 0x1234 -> aluctl 0110, alurslt 0, zero 1, branch_eq 1, regwrite 0.
- lw: opcode 0x23, rs_data 0x100, seimm 0xFFFFFFFC -> alurslt 0xFC, memread 1, memtoreg 1, alusrc 1, regwrite 1.
- slt signed: funct 0x2A, rs_data 0xFFFFFFFF, rt_data 1 -> alurslt 1. Swapped operands -> alurslt 0, zero 1.
- Unknown opcode 0x3F -> all control flags 0. Funct 0x26 -> alurslt = A^B with MIPS_ALU_XOR_EN defined; A+B without it.
- Control inputs:
  - hold high for 2 cycles with changing inputs -> outputs unchanged.
  - bubble with hold high -> all outputs 0.
  - rst mid-stream -> all outputs 0 next cycle, normal load afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute-stage decode and ALU.
// Build option: MIPS_ALU_XOR_EN adds an XOR ALU operation (funct 0x26).
package mips_pkg;

  // Instruction opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation class produced by the main decoder
  localparam logic [1:0] ALUOP_ADD0  = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD1  = 2'b11;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // Main-control bundle carried through the EX boundary register
  typedef struct packed {
    logic       regdst;
    logic       branch_eq;
    logic       branch_ne;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrc;
    logic       jump;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_core.sv
// Combinational 32-bit MIPS ALU with zero detect.
// Build option: MIPS_ALU_XOR_EN enables the XOR operation (code 1101).
module mips_alu_core
  import mips_pkg::*;
(
  input  logic [3:0]  ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        zero
);

  // Select the operation; unknown codes produce 0
  always_comb begin
    out = 32'h0;
    case (ctl)
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_ADD: out = a + b;
      ALU_SUB: out = a - b;
      ALU_SLT: out = {31'h0, ($signed(a) < $signed(b))};
      ALU_NOR: out = ~(a | b);
`ifdef MIPS_ALU_XOR_EN
      ALU_XOR: out = a ^ b;
`endif
      default: out = 32'h0;
    endcase
  end

  assign zero = (out == 32'h0);

endmodule

// File: rtl/mips_alu_ctrl.sv
// Execute stage: main decode, ALU-control decode, operand-B select, ALU,
// and the EX boundary register (bubble clears, hold freezes).
// Build option: MIPS_ALU_XOR_EN maps funct 0x26 to the XOR operation.
module mips_alu_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] seimm,
  input  logic        bubble,
  input  logic        hold,
  output logic        regdst,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrc,
  output logic        jump,
  output logic [1:0]  aluop,
  output logic [3:0]  aluctl,
  output logic [31:0] alurslt,
  output logic        zero
);

  ctrl_t       ctrl_d;
  ctrl_t       ctrl_q;
  logic [3:0]  aluctl_d;
  logic [31:0] operand_b;
  logic [31:0] result_d;
  logic        zero_d;

  // Main decode: opcode to control flags and ALU op class
  always_comb begin
    ctrl_d = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_d.regdst   = 1'b1;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.aluop    = ALUOP_RTYPE;
      end
      OP_LW: begin
        ctrl_d.memread  = 1'b1;
        ctrl_d.memtoreg = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.regwrite = 1'b1;
      end
      OP_SW: begin
        ctrl_d.memwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_d.branch_eq = 1'b1;
        ctrl_d.aluop     = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_d.branch_ne = 1'b1;
        ctrl_d.aluop     = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.regwrite = 1'b1;
      end
      OP_J: begin
        ctrl_d.jump = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // ALU-control decode: op class plus funct to a 4-bit ALU operation
  always_comb begin
    aluctl_d = ALU_ADD;
    case (ctrl_d.aluop)
      ALUOP_ADD0: aluctl_d = ALU_ADD;
      ALUOP_SUB:  aluctl_d = ALU_SUB;
      ALUOP_ADD1: aluctl_d = ALU_ADD;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  aluctl_d = ALU_ADD;
          FN_SUB:  aluctl_d = ALU_SUB;
          FN_AND:  aluctl_d = ALU_AND;
          FN_OR:   aluctl_d = ALU_OR;
          FN_SLT:  aluctl_d = ALU_SLT;
          FN_NOR:  aluctl_d = ALU_NOR;
`ifdef MIPS_ALU_XOR_EN
          FN_XOR:  aluctl_d = ALU_XOR;
`endif
          default: aluctl_d = ALU_ADD;
        endcase
      end
      default: aluctl_d = ALU_ADD;
    endcase
  end

  assign operand_b = ctrl_d.alusrc ? seimm : rt_data;

  mips_alu_core u_alu (
    .ctl  (aluctl_d),
    .a    (rs_data),
    .b    (operand_b),
    .out  (result_d),
    .zero (zero_d)
  );

  // EX boundary register: reset/bubble clear to NOP, hold freezes, else load
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ctrl_q  <= '0;
      aluctl  <= 4'h0;
      alurslt <= 32'h0;
      zero    <= 1'b0;
    end else if (!hold) begin
      ctrl_q  <= ctrl_d;
      aluctl  <= aluctl_d;
      alurslt <= result_d;
      zero    <= zero_d;
    end
  end

  assign regdst    = ctrl_q.regdst;
  assign branch_eq = ctrl_q.branch_eq;
  assign branch_ne = ctrl_q.branch_ne;
  assign memread   = ctrl_q.memread;
  assign memwrite  = ctrl_q.memwrite;
  assign memtoreg  = ctrl_q.memtoreg;
  assign regwrite  = ctrl_q.regwrite;
  assign alusrc    = ctrl_q.alusrc;
  assign jump      = ctrl_q.jump;
  assign aluop     = ctrl_q.aluop;

endmodule

// File: tb/tb_mips_alu_ctrl.sv
// Scoreboard bench for mips_alu_ctrl: directed vectors with hand-computed
// expectations queued at issue time and compared one cycle later.
module tb_mips_alu_ctrl;

  typedef struct packed {
    logic [8:0]  flags;
    logic [1:0]  aluop;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] seimm;
  logic        bubble;
  logic        hold;
  logic        regdst, branch_eq, branch_ne, memread, memwrite;
  logic        memtoreg, regwrite, alusrc, jump;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] alurslt;
  logic        zero;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks;
  int   errors;

  mips_alu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct     (funct),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .seimm     (seimm),
    .bubble    (bubble),
    .hold      (hold),
    .regdst    (regdst),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrc    (alusrc),
    .jump      (jump),
    .aluop     (aluop),
    .aluctl    (aluctl),
    .alurslt   (alurslt),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mkExp(input logic [8:0] f, input logic [1:0] op,
                                 input logic [3:0] c, input logic [31:0] r,
                                 input logic z);
    exp_t e;
    e.flags = f;
    e.aluop = op;
    e.ctl   = c;
    e.res   = r;
    e.z     = z;
    return e;
  endfunction

  // Drive one instruction on the falling edge and queue its expected result
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic r,
                               input logic bub, input logic hld, input exp_t e);
    @(negedge clk);
    opcode  = op;
    funct   = fn;
    rs_data = a;
    rt_data = b;
    seimm   = imm;
    rst     = r;
    bubble  = bub;
    hold    = hld;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("flags", {23'h0, regdst, branch_eq, branch_ne, memread, memwrite,
                         memtoreg, regwrite, alusrc, jump}, {23'h0, e.flags});
    checkField("aluop", {30'h0, aluop}, {30'h0, e.aluop});
    checkField("aluctl", {28'h0, aluctl}, {28'h0, e.ctl});
    checkField("alurslt", alurslt, e.res);
    checkField("zero", {31'h0, zero}, {31'h0, e.z});
  endtask

  // Monitor: shortly after every rising edge, compare against the oldest entry
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Directed vector sequence
  initial begin
    exp_t zero_e;
    exp_t held;
    exp_t x26;
    int   wait_cycles;
    checks = 0;
    errors = 0;
    rst = 1'b1; bubble = 1'b0; hold = 1'b0;
    opcode = 6'h0; funct = 6'h0; rs_data = 32'h0; rt_data = 32'h0; seimm = 32'h0;
    zero_e = mkExp(9'h000, 2'b00, 4'h0, 32'h0, 1'b0);
`ifdef MIPS_ALU_XOR_EN
    x26 = mkExp(9'h104, 2'b10, 4'hD, 32'h0000FF00, 1'b0);
`else
    x26 = mkExp(9'h104, 2'b10, 4'h2, 32'h000100E0, 1'b0);
`endif

    applyStimulus(6'h00, 6'h20, 32'd5, 32'd3, 32'h0, 1'b1, 1'b0, 1'b0, zero_e);
    applyStimulus(6'h00, 6'h20, 32'd5, 32'd3, 32'h0, 1'b1, 1'b0, 1'b0, zero_e);
    applyStimulus(6'h00, 6'h20, 32'd5, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'h2, 32'd8, 1'b0));
    applyStimulus(6'h04, 6'h00, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h080, 2'b01, 4'h6, 32'h0, 1'b1));
    applyStimulus(6'h23, 6'h00, 32'h100, 32'h55, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h02E, 2'b00, 4'h2, 32'hFC, 1'b0));
    applyStimulus(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'h7, 32'd1, 1'b0));
    applyStimulus(6'h00, 6'h2A, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'h7, 32'd0, 1'b1));
    applyStimulus(6'h3F, 6'h00, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h000, 2'b00, 4'h2, 32'h30, 1'b0));
    applyStimulus(6'h00, 6'h26, 32'hF0F0, 32'h0FF0, 32'h0, 1'b0, 1'b0, 1'b0, x26);
    applyStimulus(6'h00, 6'h22, 32'd10, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'h6, 32'd7, 1'b0));
    applyStimulus(6'h00, 6'h22, 32'd0, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'h6, 32'hFFFFFFFF, 1'b0));
    applyStimulus(6'h00, 6'h24, 32'hC, 32'hA, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'h0, 32'h8, 1'b0));
    applyStimulus(6'h00, 6'h25, 32'hC, 32'hA, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'h1, 32'hE, 1'b0));
    applyStimulus(6'h00, 6'h27, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'hC, 32'hFFFFFFFF, 1'b0));
    applyStimulus(6'h00, 6'h00, 32'd4, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h104, 2'b10, 4'h2, 32'd8, 1'b0));
    applyStimulus(6'h2B, 6'h00, 32'h200, 32'h77, 32'h8, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h012, 2'b00, 4'h2, 32'h208, 1'b0));
    applyStimulus(6'h05, 6'h00, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h040, 2'b01, 4'h6, 32'hFFFFFFFF, 1'b0));
    applyStimulus(6'h08, 6'h00, 32'd7, 32'd100, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h006, 2'b00, 4'h2, 32'd6, 1'b0));
    applyStimulus(6'h02, 6'h00, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h001, 2'b00, 4'h2, 32'd2, 1'b0));

    // Hold for two cycles with changing inputs: outputs stay at the j result
    held = last_exp;
    applyStimulus(6'h04, 6'h00, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0, 1'b1, held);
    applyStimulus(6'h23, 6'h00, 32'h40, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1, held);
    // Bubble wins over hold
    applyStimulus(6'h00, 6'h20, 32'd5, 32'd3, 32'h0, 1'b0, 1'b1, 1'b1, zero_e);
    applyStimulus(6'h23, 6'h00, 32'h100, 32'h0, 32'h10, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h02E, 2'b00, 4'h2, 32'h110, 1'b0));
    // Reset mid-stream discards the instruction, next cycle loads normally
    applyStimulus(6'h00, 6'h20, 32'd9, 32'd9, 32'h0, 1'b1, 1'b0, 1'b0, zero_e);
    applyStimulus(6'h2B, 6'h00, 32'h300, 32'h1, 32'h4, 1'b0, 1'b0, 1'b0,
                  mkExp(9'h012, 2'b00, 4'h2, 32'h304, 1'b0));

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
